// File: rtl/reg_bank_mp.sv
// -----------------------------------------------------------------------------
// reg_bank_mp
// Parametrised multi-port register bank. It has one write port and two
// independent registered read ports: port A feeds the X operand and port B
// feeds the Y operand. A per-register busy scoreboard lets the multicycle
// controller wait for pending writes.
//
// Optional feature macro: REGBANK_FWD_EN
//   defined   : a read of the register being written in the same cycle returns
//               wdata_i. vld is 1 unless the same edge re-reserves it.
//   undefined : a same-cycle read returns the old contents. vld then follows
//               the busy bit as it was before the edge.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   clr_i        synchronous clear of all registers, busy bits and vld
//   we_i         write enable
//   waddr_i      write address
//   wdata_i      write data
//   rsv_i        reserve: set busy for rsv_addr_i
//   rsv_addr_i   register to reserve
//   re_a_i       read request, port A
//   raddr_a_i    read address, port A
//   rdata_a_o    registered read data, port A
//   vld_a_o      rdata_a_o valid pulse
//   re_b_i       read request, port B
//   raddr_b_i    read address, port B
//   rdata_b_o    registered read data, port B
//   vld_b_o      rdata_b_o valid pulse
//   busy_o       per-register pending-write flags
//
// Read handshake: when re is high at a rising edge, the request is sampled.
// After that same edge, vld is high for exactly one cycle if the data is
// usable. If vld stays low, the target was busy: rdata keeps its previous
// value and the requester must issue re again. There is no ready signal, and
// no request is held inside the bank.
// Addresses at or above DEPTH are out of range. Writes and reserves to them
// are dropped. Reads of them return 0 with vld=1.
// -----------------------------------------------------------------------------
module reg_bank_mp #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rsv_i,
   input  logic [AW-1:0]    rsv_addr_i,
   input  logic             re_a_i,
   input  logic [AW-1:0]    raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   output logic             vld_a_o,
   input  logic             re_b_i,
   input  logic [AW-1:0]    raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o,
   output logic             vld_b_o,
   output logic [DEPTH-1:0] busy_o
);

   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [WIDTH-1:0] rdata_q [2];
   logic [WIDTH-1:0] rdata_d [2];
   logic [1:0]       vld_q, vld_d;
   logic [1:0]       re;
   logic [AW-1:0]    ra [2];

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_W;
   endfunction

   assign re[0] = re_a_i;
   assign re[1] = re_b_i;
   assign ra[0] = raddr_a_i;
   assign ra[1] = raddr_b_i;

   // Storage and scoreboard. The reserve is applied after the write, so a
   // same-address reserve leaves the register busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
         busy_d = '0;
      end else begin
         if (we_i && in_range(waddr_i)) begin
            regs_d[waddr_i] = wdata_i;
            busy_d[waddr_i] = 1'b0;
         end
         if (rsv_i && in_range(rsv_addr_i)) busy_d[rsv_addr_i] = 1'b1;
      end
   end

   // Read ports. Both ports use the same rule, so they return identical data
   // when they read the same address.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata_d[p] = rdata_q[p];
         vld_d[p]   = 1'b0;
         if (!clr_i && re[p]) begin
            if (!in_range(ra[p])) begin
               rdata_d[p] = '0;
               vld_d[p]   = 1'b1;
            end else begin
`ifdef REGBANK_FWD_EN
               // Forwarding: the post-edge busy bit already accounts for a
               // same-cycle write (clears it) and a reserve (sets it again).
               if (!busy_d[ra[p]]) begin
                  vld_d[p]   = 1'b1;
                  rdata_d[p] = (we_i && waddr_i == ra[p]) ? wdata_i : regs_q[ra[p]];
               end
`else
               // No forwarding: a read that collides with the write sees the
               // old contents, so its validity is judged by the old busy bit.
               if ((we_i && waddr_i == ra[p]) ? !busy_q[ra[p]] : !busy_d[ra[p]]) begin
                  vld_d[p]   = 1'b1;
                  rdata_d[p] = regs_q[ra[p]];
               end
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q     <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
         vld_q      <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
         vld_q      <= vld_d;
      end
   end

   assign rdata_a_o = rdata_q[0];
   assign rdata_b_o = rdata_q[1];
   assign vld_a_o   = vld_q[0];
   assign vld_b_o   = vld_q[1];
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Testbench for reg_bank_mp. It uses DEPTH=6, so addresses 6 and 7 are out
// of range. A behavioural model of the bank queues the expected outputs after
// every edge, and a compare step checks the DUT against them.
module tb_reg_bank_mp;
   localparam int WIDTH = 16;
   localparam int DEPTH = 6;
   localparam int AW    = 3;
   localparam int W     = DEPTH + 2 + 2 * WIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b1;

   logic             clr, we, rsv, re_a, re_b;
   logic [AW-1:0]    waddr, rsv_addr, raddr_a, raddr_b;
   logic [WIDTH-1:0] wdata, rdata_a, rdata_b;
   logic             vld_a, vld_b;
   logic [DEPTH-1:0] busy;

   reg_bank_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .rsv_i(rsv), .rsv_addr_i(rsv_addr),
      .re_a_i(re_a), .raddr_a_i(raddr_a), .rdata_a_o(rdata_a), .vld_a_o(vld_a),
      .re_b_i(re_b), .raddr_b_i(raddr_b), .rdata_b_o(rdata_b), .vld_b_o(vld_b),
      .busy_o(busy)
   );

   // ---------------- model + scoreboard ----------------
   logic [WIDTH-1:0] m_regs [DEPTH];
   logic [DEPTH-1:0] m_busy;
   logic [WIDTH-1:0] m_rd [2];
   logic             m_vld [2];
   logic [W-1:0]     exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_push();
      exp_q.push_back({m_busy, m_vld[1], m_vld[0], m_rd[1], m_rd[0]});
   endtask

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_busy = '0;
      for (int p = 0; p < 2; p++) begin m_rd[p] = '0; m_vld[p] = 1'b0; end
      exp_q.delete();
      model_push();
   endtask

   // One rising edge, computed from the bank's rules using the inputs held
   // across the edge.
   task automatic model_edge();
      logic [WIDTH-1:0] old_regs [DEPTH];
      logic [DEPTH-1:0] old_busy;
      logic             pre [2];
      int               pa [2];
      int               wa, a;
      logic             hit, ok;
      logic [WIDTH-1:0] val;
      old_regs = m_regs;
      old_busy = m_busy;
      pre[0] = re_a; pre[1] = re_b;
      pa[0] = int'(raddr_a); pa[1] = int'(raddr_b);
      wa = int'(waddr);
      if (clr) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         m_busy = '0;
         m_vld[0] = 1'b0; m_vld[1] = 1'b0;
      end else begin
         if (we && wa < DEPTH) begin m_regs[wa] = wdata; m_busy[wa] = 1'b0; end
         if (rsv && int'(rsv_addr) < DEPTH) m_busy[int'(rsv_addr)] = 1'b1;
         for (int p = 0; p < 2; p++) begin
            m_vld[p] = 1'b0;
            if (pre[p]) begin
               a = pa[p];
               if (a >= DEPTH) begin
                  m_rd[p] = '0; m_vld[p] = 1'b1;
               end else begin
                  hit = we && (wa == a);
`ifdef REGBANK_FWD_EN
                  ok  = !m_busy[a];
                  val = hit ? wdata : old_regs[a];
`else
                  ok  = hit ? !old_busy[a] : !m_busy[a];
                  val = old_regs[a];
`endif
                  if (ok) begin m_rd[p] = val; m_vld[p] = 1'b1; end
               end
            end
         end
      end
      model_push();
   endtask

   task automatic compare();
      logic [W-1:0] got, exp;
      got = {busy, vld_b, vld_a, rdata_b, rdata_a};
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard: expected queue empty, got %h", got);
      end else begin
         exp = exp_q.pop_front();
         check("cycle busy|vld_b|vld_a|rdata_b|rdata_a", 64'(got), 64'(exp));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      clr = 0; we = 0; rsv = 0; re_a = 0; re_b = 0;
      waddr = '0; wdata = '0; rsv_addr = '0; raddr_a = '0; raddr_b = '0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic write(input int a, input logic [WIDTH-1:0] d);
      we = 1; waddr = AW'(a); wdata = d;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare();
      repeat (2) @(posedge clk);
      #1;
      check("reset hold rdata_a", rdata_a, 0);
      check("reset hold busy", busy, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      #2;
      // Reset while a write is presented: nothing may be captured.
      write(1, 16'hFFFF);
      apply_reset();
      check("reset vld_a", vld_a, 0);
      check("reset vld_b", vld_b, 0);
      check("reset rdata_b", rdata_b, 0);
      idle();
      re_a = 1; raddr_a = 3'd1;
      step();
      check("reset reg1 not written", rdata_a, 16'h0000);

      // Write, then read on the next cycle.
      idle(); write(5, 16'h1234); step();
      idle(); re_a = 1; raddr_a = 3'd5; step();
      check("rd r5 data", rdata_a, 16'h1234);
      check("rd r5 vld", vld_a, 1);
      idle(); step();
      check("vld_a one pulse", vld_a, 0);
      check("rdata_a holds", rdata_a, 16'h1234);

      // Reserve, blocked read, write clears busy, then re-read.
      idle(); rsv = 1; rsv_addr = 3'd3; step();
      check("busy3 set", busy[3], 1);
      idle(); re_b = 1; raddr_b = 3'd3; step();
      check("busy read vld_b", vld_b, 0);
      idle(); write(3, 16'h00A5); step();
      check("busy3 cleared", busy[3], 0);
      idle(); re_b = 1; raddr_b = 3'd3; step();
      check("reread r3", rdata_b, 16'h00A5);
      check("reread vld_b", vld_b, 1);

      // Read of the register being written, on both ports.
      idle(); write(2, 16'h0001); step();
      idle(); write(2, 16'hBEEF); re_a = 1; raddr_a = 3'd2; re_b = 1; raddr_b = 3'd2; step();
`ifdef REGBANK_FWD_EN
      check("same-cycle rd a", rdata_a, 16'hBEEF);
      check("same-cycle rd b", rdata_b, 16'hBEEF);
`else
      check("same-cycle rd a", rdata_a, 16'h0001);
      check("same-cycle rd b", rdata_b, 16'h0001);
`endif
      check("same-cycle vld_a", vld_a, 1);

      // Out-of-range write and reads.
      idle(); write(7, 16'h5555); step();
      idle(); re_a = 1; raddr_a = 3'd7; re_b = 1; raddr_b = 3'd6; step();
      check("oor rdata_a", rdata_a, 0);
      check("oor vld_a", vld_a, 1);
      check("oor vld_b", vld_b, 1);

      // Clear overrides a write and a reserve.
      idle(); write(1, 16'h7777); step();
      idle(); clr = 1; write(1, 16'h7777); rsv = 1; rsv_addr = 3'd4; step();
      check("clr busy", busy, 0);
      idle(); re_a = 1; raddr_a = 3'd1; step();
      check("clr r1", rdata_a, 0);
      idle(); write(4, 16'h0F0F); rsv = 1; rsv_addr = 3'd4; step();
      check("rsv wins busy4", busy[4], 1);

      // Reset while a read is pending.
      idle(); re_a = 1; raddr_a = 3'd5; #2;
      apply_reset();
      idle(); step();
      check("post-reset vld_a", vld_a, 0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         clr      = ($urandom_range(0, 63) == 0);
         we       = ($urandom_range(0, 1) == 1);
         waddr    = AW'($urandom_range(0, 7));
         wdata    = WIDTH'($urandom);
         rsv      = ($urandom_range(0, 3) == 0);
         rsv_addr = AW'($urandom_range(0, 7));
         re_a     = ($urandom_range(0, 9) < 6);
         raddr_a  = AW'($urandom_range(0, 7));
         re_b     = ($urandom_range(0, 9) < 6);
         raddr_b  = ($urandom_range(0, 3) == 0) ? raddr_a : AW'($urandom_range(0, 7));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
